// File: rtl/toy_pack.sv
// Shared icache types: request payload, MSHR index width and
// request arbiter constants (mode selectors, channel numbering).
package toy_pack;

  localparam int MSHR_ENTRY_INDEX_WIDTH = 4;

  localparam int ARB_MODE_RR    = 0;
  localparam int ARB_MODE_FIXED = 1;

  localparam int ICACHE_ARB_CH_NUM = 3;

  typedef enum logic [1:0] {
    ARB_CH_UPSTREAM = 2'd0,
    ARB_CH_SNOOP    = 2'd1,
    ARB_CH_PREFETCH = 2'd2
  } arb_ch_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  tid;
  } pc_req_t;

endpackage

// File: rtl/icache_rr_picker.sv
// Combinational rotating picker: first request at or after ptr,
// or the lowest request index when fixed is set.
module icache_rr_picker #(
  parameter  int CH_NUM = 3,
  localparam int SRC_W  = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [SRC_W-1:0]  ptr,
  input  logic              fixed,
  output logic [CH_NUM-1:0] gnt,
  output logic [SRC_W-1:0]  idx
);

  int               c;
  logic [SRC_W-1:0] ci;

  // scan from the far end so the nearest request is written last
  always_comb begin
    gnt = '0;
    idx = '0;
    c   = 0;
    ci  = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      c = (fixed ? 0 : int'(ptr)) + k;
      if (c >= CH_NUM) c = c - CH_NUM;
      ci = SRC_W'(c);
      if (req[ci]) begin
        gnt     = '0;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/icache_mc_req_arbiter.sv
// N-channel icache request arbiter with MSHR allocation and a registered
// tag request. Optional starvation guard: ICACHE_ARB_STARVE_GUARD_EN.
module icache_mc_req_arbiter
  import toy_pack::*;
#(
  parameter  int CH_NUM       = 3,
  parameter  int PRIO_MODE    = 0,
  parameter  int STARVE_LIMIT = 15,
  parameter  int IDX_W        = MSHR_ENTRY_INDEX_WIDTH,
  localparam int SRC_W        = $clog2(CH_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CH_NUM-1:0]          ch_req_vld,
  output logic [CH_NUM-1:0]          ch_req_rdy,
  input  pc_req_t [CH_NUM-1:0]       ch_req_pld,
  input  logic                       arb_hold,
  output logic                       alloc_vld,
  input  logic                       alloc_rdy,
  input  logic [IDX_W-1:0]           alloc_index,
  output logic                       tag_req_vld,
  input  logic                       tag_req_rdy,
  output pc_req_t                    tag_req_pld,
  output logic [IDX_W-1:0]           tag_req_index,
  output logic [SRC_W-1:0]           tag_req_src
);

  logic              slot_free;
  logic              fire;
  logic [CH_NUM-1:0] pick_req;
  logic              pick_fixed;
  logic [CH_NUM-1:0] gnt;
  logic [SRC_W-1:0]  gidx;
  logic [SRC_W-1:0]  ptr;

  assign slot_free  = !tag_req_vld || tag_req_rdy;
  assign alloc_vld  = rst_n && (|ch_req_vld) && slot_free && !arb_hold;
  assign fire       = alloc_vld && alloc_rdy;
  assign ch_req_rdy = fire ? gnt : '0;

`ifdef ICACHE_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]  cnt [CH_NUM];
  logic [CH_NUM-1:0] starved;

  always_comb begin
    starved = '0;
    for (int i = 0; i < CH_NUM; i++)
      starved[i] = ch_req_vld[i] &&
                   (cnt[i] == CNT_W'(STARVE_LIMIT));
  end

  // starved channels bypass the pointer: lowest starved index wins
  assign pick_req   = (|starved) ? starved : ch_req_vld;
  assign pick_fixed = (|starved) || (PRIO_MODE == ARB_MODE_FIXED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (!ch_req_vld[i] || ch_req_rdy[i])
          cnt[i] <= '0;
        else if (cnt[i] != CNT_W'(STARVE_LIMIT))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end
`else
  assign pick_req   = ch_req_vld;
  assign pick_fixed = (PRIO_MODE == ARB_MODE_FIXED);
`endif

  icache_rr_picker #(
    .CH_NUM (CH_NUM)
  ) u_picker (
    .req   (pick_req),
    .ptr   (ptr),
    .fixed (pick_fixed),
    .gnt   (gnt),
    .idx   (gidx)
  );

  if (PRIO_MODE == ARB_MODE_RR) begin : g_rr
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        ptr <= '0;
      else if (fire)
        ptr <= (gidx == SRC_W'(CH_NUM - 1)) ?
               '0 : gidx + SRC_W'(1);
    end
  end else begin : g_fixed
    assign ptr = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_req_vld   <= 1'b0;
      tag_req_pld   <= '0;
      tag_req_index <= '0;
      tag_req_src   <= '0;
    end else if (fire) begin
      tag_req_vld   <= 1'b1;
      tag_req_pld   <= ch_req_pld[gidx];
      tag_req_index <= alloc_index;
      tag_req_src   <= gidx;
    end else if (tag_req_rdy) begin
      tag_req_vld   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_mc_req_arbiter.sv
// Bench: round-robin and fixed-priority arbiters against a reference
// model, directed scenarios followed by randomized traffic.
module tb_icache_mc_req_arbiter;
  import toy_pack::*;

  localparam int N    = 3;
  localparam int LIM0 = 15;
  localparam int LIM1 = 4;
`ifdef ICACHE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic [N-1:0]      vld  [2];
  pc_req_t [N-1:0]   pld  [2];
  logic              hold [2];
  logic              ardy [2];
  logic              trdy [2];
  logic [3:0]        aidx [2];
  logic [N-1:0]      rdy  [2];
  logic              avld [2];
  logic              tvld [2];
  pc_req_t           tpld [2];
  logic [3:0]        tidx [2];
  logic [1:0]        tsrc [2];

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic         mv   [2];
  pc_req_t      mp   [2];
  logic [3:0]   mi   [2];
  int           ms   [2];
  int           nxt  [2];
  int           cnt  [2][N];
  logic         e_av [2];
  logic         e_fire [2];
  int           e_w  [2];
  logic [N-1:0] e_rdy [2];
  logic [N-1:0] acc  [2];

  always #5 clk = ~clk;

  icache_mc_req_arbiter #(
    .CH_NUM(N), .PRIO_MODE(ARB_MODE_RR),
    .STARVE_LIMIT(LIM0), .IDX_W(4)
  ) u_rr (
    .clk(clk), .rst_n(rst_n),
    .ch_req_vld(vld[0]), .ch_req_rdy(rdy[0]),
    .ch_req_pld(pld[0]), .arb_hold(hold[0]),
    .alloc_vld(avld[0]), .alloc_rdy(ardy[0]),
    .alloc_index(aidx[0]), .tag_req_vld(tvld[0]),
    .tag_req_rdy(trdy[0]), .tag_req_pld(tpld[0]),
    .tag_req_index(tidx[0]), .tag_req_src(tsrc[0])
  );

  icache_mc_req_arbiter #(
    .CH_NUM(N), .PRIO_MODE(ARB_MODE_FIXED),
    .STARVE_LIMIT(LIM1), .IDX_W(4)
  ) u_fx (
    .clk(clk), .rst_n(rst_n),
    .ch_req_vld(vld[1]), .ch_req_rdy(rdy[1]),
    .ch_req_pld(pld[1]), .arb_hold(hold[1]),
    .alloc_vld(avld[1]), .alloc_rdy(ardy[1]),
    .alloc_index(aidx[1]), .tag_req_vld(tvld[1]),
    .tag_req_rdy(trdy[1]), .tag_req_pld(tpld[1]),
    .tag_req_index(tidx[1]), .tag_req_src(tsrc[1])
  );

  function automatic int lim(int i);
    return (i == 0) ? LIM0 : LIM1;
  endfunction

  task automatic chk(string tag, int i, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s u%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; mp[i] = '0; mi[i] = '0; ms[i] = 0;
      nxt[i] = 0; acc[i] = '0;
      for (int c = 0; c < N; c++) cnt[i][c] = 0;
    end
  endtask

  task automatic predict(int i);
    int w;
    int c;
    w = -1;
    if (GUARD)
      for (int k = 0; k < N; k++)
        if (w < 0 && vld[i][k] && cnt[i][k] >= lim(i)) w = k;
    for (int k = 0; k < N; k++) begin
      c = (i == 0) ? (nxt[i] + k) % N : k;
      if (w < 0 && vld[i][c]) w = c;
    end
    e_av[i]   = (vld[i] != '0) && (!mv[i] || trdy[i]) && !hold[i];
    e_fire[i] = e_av[i] && ardy[i];
    e_w[i]    = w;
    e_rdy[i]  = e_fire[i] ? N'(1 << w) : '0;
  endtask

  task automatic compare(int i);
    chk("ch_req_rdy", i, 64'(rdy[i]), 64'(e_rdy[i]));
    chk("alloc_vld", i, 64'(avld[i]), 64'(e_av[i]));
    chk("tag_req_vld", i, 64'(tvld[i]), 64'(mv[i]));
    chk("tag_req_pld", i, 64'(tpld[i]), 64'(mp[i]));
    chk("tag_req_index", i, 64'(tidx[i]), 64'(mi[i]));
    chk("tag_req_src", i, 64'(tsrc[i]), 64'(ms[i]));
  endtask

  task automatic commit(int i);
    for (int c = 0; c < N; c++) begin
      if (!vld[i][c] || (e_fire[i] && e_w[i] == c)) cnt[i][c] = 0;
      else if (cnt[i][c] < lim(i)) cnt[i][c]++;
    end
    if (e_fire[i]) begin
      mv[i] = 1'b1;
      mp[i] = pld[i][e_w[i]];
      mi[i] = aidx[i];
      ms[i] = e_w[i];
      nxt[i] = (e_w[i] + 1) % N;
    end else if (trdy[i]) begin
      mv[i] = 1'b0;
    end
    acc[i] = e_rdy[i];
  endtask

  // sources only change vld/pld once the request was accepted or idle
  task automatic gen(int i, logic [N-1:0] fmask, logic rnd);
    for (int c = 0; c < N; c++)
      if (!vld[i][c] || acc[i][c]) begin
        vld[i][c] = fmask[c] | (rnd & 1'($urandom));
        pld[i][c] = pc_req_t'({$urandom, 4'($urandom)});
      end
  endtask

  task automatic drive(int i, logic h, logic a, logic t);
    hold[i] = h; ardy[i] = a; trdy[i] = t;
  endtask

  task automatic step();
    for (int i = 0; i < 2; i++) predict(i);
    #1;
    for (int i = 0; i < 2; i++) compare(i);
    @(posedge clk);
    for (int i = 0; i < 2; i++) commit(i);
    @(negedge clk);
  endtask

  task automatic zero_check(string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_rdy"}, i, 64'(rdy[i]), 64'(0));
      chk({tag, "_avld"}, i, 64'(avld[i]), 64'(0));
      chk({tag, "_tvld"}, i, 64'(tvld[i]), 64'(0));
      chk({tag, "_tpld"}, i, 64'(tpld[i]), 64'(0));
      chk({tag, "_tidx"}, i, 64'(tidx[i]), 64'(0));
      chk({tag, "_tsrc"}, i, 64'(tsrc[i]), 64'(0));
    end
  endtask

  int exp_src;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld[i] = '0; pld[i] = '0; aidx[i] = '0;
      drive(i, 1'b0, 1'b0, 1'b0);
    end
    model_reset();
    #2;
    zero_check("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // all channels held: RR rotates, fixed favours channel 1
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b1, 1'b1);
      aidx[0] = 4'(5 + k % 3);
      aidx[1] = 4'(k);
      gen(0, 3'b111, 1'b0);
      gen(1, 3'b110, 1'b0);
      step();
      chk("rr_src", 0, 64'(tsrc[0]), 64'(k % 3));
      chk("rr_idx", 0, 64'(tidx[0]), 64'(5 + k % 3));
      chk("fx_src", 1, 64'(tsrc[1]), 64'((GUARD && k == 4) ? 2 : 1));
    end

    // tag pipe back-pressure
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin
        drive(i, 1'b0, 1'b1, 1'b0);
        gen(i, 3'b111, 1'b0);
      end
      step();
      chk("bp_avld", 0, 64'(avld[0]), 64'(0));
      chk("bp_tvld", 0, 64'(tvld[0]), 64'(1));
    end
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b1, 1'b1);
    step();

    // MSHR full: no grant, pointer frozen
    exp_src = nxt[0];
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        drive(i, 1'b0, 1'b0, 1'b1);
        gen(i, 3'b111, 1'b0);
      end
      step();
    end
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b1, 1'b1);
    step();
    chk("stall_src", 0, 64'(tsrc[0]), 64'(exp_src));
    chk("stall_tvld", 0, 64'(tvld[0]), 64'(1));

    // hold: registered request drains, nothing new granted
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) drive(i, 1'b1, 1'b1, 1'b1);
      step();
      chk("hold_tvld", 0, 64'(tvld[0]), 64'(0));
      chk("hold_tvld", 1, 64'(tvld[1]), 64'(0));
    end

    // randomized traffic with a reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        #3;
        rst_n = 1'b0;
        #1;
        zero_check("midreset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b1, 1'b1);
        gen(0, 3'b001, 1'b0);
        gen(1, 3'b000, 1'b0);
        step();
        chk("post_reset_src", 0, 64'(tsrc[0]), 64'(0));
        chk("post_reset_tvld", 0, 64'(tvld[0]), 64'(1));
      end
      for (int i = 0; i < 2; i++) begin
        drive(i, ($urandom % 8) == 0, ($urandom % 4) != 0,
              ($urandom % 4) != 0);
        aidx[i] = 4'($urandom);
        gen(i, 3'b000, 1'b1);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
